// File: rtl/rpc2_pkg.sv
// Shared types and constants for the RPC2 RX packer slice.
package rpc2_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] STRB_LO  = 4'b0011;
  localparam logic [3:0] STRB_HI  = 4'b1100;
  localparam logic [3:0] STRB_ALL = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY,
    PEND,
    PEND_LAST
  } state_t;

  // One FIFO entry: 39 bits {last, resp, strb, data}.
  typedef struct packed {
    logic        last;
    logic [1:0]  resp;
    logic [3:0]  strb;
    logic [31:0] data;
  } word_t;

  function automatic word_t make_word(input logic        last,
                                      input logic [1:0]  resp,
                                      input logic [3:0]  strb,
                                      input logic [31:0] data);
    word_t w;
    w.last = last;
    w.resp = resp;
    w.strb = strb;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/rpc2_rx_packer_if.sv
// RX half-word input and packed-word output handshakes of the packer.
interface rpc2_rx_packer_if;

  logic        rx_data_valid;
  logic [15:0] rx_data;
  logic        rx_data_addr;
  logic        rx_data_last;
  logic [1:0]  rx_error;
  logic        rx_stall;
  logic        rx_data_ready;

  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_strb;
  logic [1:0]  rd_resp;
  logic        rd_last;
  logic        rd_ready;

  // Packer side.
  modport slave (
    input  rx_data_valid, rx_data, rx_data_addr, rx_data_last, rx_error, rx_stall,
    output rx_data_ready,
    output rd_valid, rd_data, rd_strb, rd_resp, rd_last,
    input  rd_ready
  );

  // Environment side: drives halves, consumes words.
  modport master (
    output rx_data_valid, rx_data, rx_data_addr, rx_data_last, rx_error, rx_stall,
    input  rx_data_ready,
    input  rd_valid, rd_data, rd_strb, rd_resp, rd_last,
    output rd_ready
  );

endinterface

// File: rtl/rpc2_word_fifo.sv
// Synchronous show-ahead FIFO of packed words; head is visible while not empty.
module rpc2_word_fifo
  import rpc2_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push,
  input  word_t push_word,
  input  logic  pop,
  output word_t head,
  output logic  empty,
  output logic  full
);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rpc2_rx_packer.sv
// Packs 16-bit RX halves into 32-bit words with strobes/resp/last and queues them.
// Optional macro RPC2_RX_STALL_RESP_EN: rx_stall on an accepted half forces SLVERR
// for that word and the rest of the burst.
module rpc2_rx_packer
  import rpc2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  rpc2_rx_packer_if.slave bus
);

  state_t      state;
  state_t      state_next;
  logic [15:0] pend_data;
  logic [15:0] pend_data_next;
  logic        pend_last;
  logic        pend_last_next;
  logic [1:0]  burst_resp;
  logic [1:0]  burst_resp_next;
  logic        burst_first;
  logic        burst_first_next;
  logic [1:0]  cur_resp;
  logic        run;
  logic        rx_ready;
  logic        accept;
  logic        push;
  word_t       push_word;
  word_t       head;
  word_t       rd_word;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;

  assign rx_ready          = run & ~fifo_full & (state != PEND_LAST);
  assign accept            = bus.rx_data_valid & rx_ready;
  assign pop               = ~fifo_empty & bus.rd_ready;
  assign bus.rx_data_ready = rx_ready;

  assign rd_word      = fifo_empty ? '0 : head;
  assign bus.rd_valid = ~fifo_empty;
  assign bus.rd_data  = rd_word.data;
  assign bus.rd_strb  = rd_word.strb;
  assign bus.rd_resp  = rd_word.resp;
  assign bus.rd_last  = rd_word.last;

`ifndef RPC2_RX_STALL_RESP_EN
  logic unused_stall;
  assign unused_stall = bus.rx_stall;
`endif

  // Response for a word pushed by this half: fresh capture at burst start, else held.
  always_comb begin
    cur_resp = burst_first ? bus.rx_error : burst_resp;
`ifdef RPC2_RX_STALL_RESP_EN
    if (bus.rx_stall) begin
      cur_resp = cur_resp | RESP_SLVERR;
    end
`endif
  end

  // Next-state, push request and pending/burst bookkeeping.
  always_comb begin
    state_next       = state;
    pend_data_next   = pend_data;
    pend_last_next   = pend_last;
    burst_resp_next  = burst_resp;
    burst_first_next = burst_first;
    push             = 1'b0;
    push_word        = '0;

    if (accept) begin
      burst_resp_next  = cur_resp;
      burst_first_next = 1'b0;
    end

    case (state)
      EMPTY: begin
        if (accept) begin
          if (bus.rx_data_addr) begin
            push      = 1'b1;
            push_word = make_word(bus.rx_data_last, cur_resp, STRB_HI, {bus.rx_data, 16'h0000});
            if (bus.rx_data_last) burst_first_next = 1'b1;
          end else if (bus.rx_data_last) begin
            push             = 1'b1;
            push_word        = make_word(1'b1, cur_resp, STRB_LO, {16'h0000, bus.rx_data});
            burst_first_next = 1'b1;
          end else begin
            pend_data_next = bus.rx_data;
            pend_last_next = 1'b0;
            state_next     = PEND;
          end
        end
      end
      PEND: begin
        if (accept) begin
          if (bus.rx_data_addr) begin
            push       = 1'b1;
            push_word  = make_word(bus.rx_data_last, cur_resp, STRB_ALL, {bus.rx_data, pend_data});
            state_next = EMPTY;
            if (bus.rx_data_last) burst_first_next = 1'b1;
          end else begin
            // A second low half flushes the held one as a lone low word.
            push           = 1'b1;
            push_word      = make_word(1'b0, cur_resp, STRB_LO, {16'h0000, pend_data});
            pend_data_next = bus.rx_data;
            pend_last_next = bus.rx_data_last;
            state_next     = bus.rx_data_last ? PEND_LAST : PEND;
          end
        end
      end
      PEND_LAST: begin
        // Input is stalled here, so the only push source is the held final half.
        if (!fifo_full) begin
          push             = 1'b1;
          push_word        = make_word(pend_last, burst_resp, STRB_LO, {16'h0000, pend_data});
          pend_last_next   = 1'b0;
          burst_first_next = 1'b1;
          state_next       = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State, pending half and burst response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      pend_data   <= '0;
      pend_last   <= 1'b0;
      burst_resp  <= RESP_OKAY;
      burst_first <= 1'b1;
      run         <= 1'b0;
    end else begin
      state       <= state_next;
      pend_data   <= pend_data_next;
      pend_last   <= pend_last_next;
      burst_resp  <= burst_resp_next;
      burst_first <= burst_first_next;
      run         <= 1'b1;
    end
  end

  rpc2_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_rpc2_rx_packer.sv
// Directed self-checking bench for rpc2_rx_packer.
module tb_rpc2_rx_packer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [38:0] got_q[$];
  logic [38:0] exp_q[$];

  rpc2_rx_packer_if bus ();

  rpc2_rx_packer #(
    .FIFO_DEPTH (4),
    .PTR_W      (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] w(input logic last, input logic [1:0] resp,
                                    input logic [3:0] strb, input logic [31:0] data);
    return {last, resp, strb, data};
  endfunction

  // Record every word transfer, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (reset_n && bus.rd_valid && bus.rd_ready)
      got_q.push_back({bus.rd_last, bus.rd_resp, bus.rd_strb, bus.rd_data});
  end

  // Offer one half; returns on the negedge after it was accepted.
  task automatic send_half(input logic [15:0] d, input logic a, input logic l,
                           input logic [1:0] e, input logic s);
    int unsigned n;
    n = 0;
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = d;
    bus.rx_data_addr  = a;
    bus.rx_data_last  = l;
    bus.rx_error      = e;
    bus.rx_stall      = s;
    while (!bus.rx_data_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_data_ready) check("half_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
    bus.rx_stall      = 1'b0;
  endtask

  task automatic compare_words(input string tag);
    check($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [1:0] resp2;
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = '0;
    bus.rx_data_addr  = 1'b0;
    bus.rx_data_last  = 1'b0;
    bus.rx_error      = '0;
    bus.rx_stall      = 1'b0;
    bus.rd_ready      = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 64'(bus.rx_data_ready), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_rd_word", 64'({bus.rd_last, bus.rd_resp, bus.rd_strb, bus.rd_data}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 64'(bus.rx_data_ready), 64'd1);

    // Full word from two halves, one-cycle latency.
    got_q.delete();
    send_half(16'h1111, 1'b0, 1'b0, 2'b00, 1'b0);
    check("t1_no_word_while_pend", 64'(bus.rd_valid), 64'd0);
    send_half(16'h2222, 1'b1, 1'b1, 2'b00, 1'b0);
    check("t1_valid", 64'(bus.rd_valid), 64'd1);
    check("t1_word", 64'({bus.rd_last, bus.rd_resp, bus.rd_strb, bus.rd_data}),
          64'(w(1'b1, 2'b00, 4'b1111, 32'h22221111)));
    repeat (3) @(negedge clk);
    exp_q.push_back(w(1'b1, 2'b00, 4'b1111, 32'h22221111));
    compare_words("t1");

    // Single low half with last.
    send_half(16'hABCD, 1'b0, 1'b1, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    exp_q.push_back(w(1'b1, 2'b00, 4'b0011, 32'h0000ABCD));
    compare_words("t2");

    // Three low halves, ready drops for one cycle in PEND_LAST.
    send_half(16'h0001, 1'b0, 1'b0, 2'b00, 1'b0);
    send_half(16'h0002, 1'b0, 1'b0, 2'b00, 1'b0);
    send_half(16'h0003, 1'b0, 1'b1, 2'b00, 1'b0);
    #1;
    check("t3_pend_last_ready", 64'(bus.rx_data_ready), 64'd0);
    @(negedge clk);
    #1;
    check("t3_ready_back", 64'(bus.rx_data_ready), 64'd1);
    repeat (4) @(negedge clk);
    exp_q.push_back(w(1'b0, 2'b00, 4'b0011, 32'h00000001));
    exp_q.push_back(w(1'b0, 2'b00, 4'b0011, 32'h00000002));
    exp_q.push_back(w(1'b1, 2'b00, 4'b0011, 32'h00000003));
    compare_words("t3");

    // Back-pressure: 10 halves into a 4-entry FIFO.
    bus.rd_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          send_half(16'h1000 + 16'(k), 1'b0, 1'b0, 2'b00, 1'b0);
          send_half(16'h2000 + 16'(k), 1'b1, (k == 4), 2'b00, 1'b0);
        end
      end
      begin
        repeat (12) @(negedge clk);
        #1;
        check("t4_full_ready_low", 64'(bus.rx_data_ready), 64'd0);
        check("t4_head", 64'(bus.rd_data), 64'h20001000);
        bus.rd_ready = 1'b1;
      end
    join
    for (int i = 0; i < 60 && got_q.size() < 5; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("t4_drained", 64'(bus.rd_valid), 64'd0);
    for (int k = 0; k < 5; k++)
      exp_q.push_back(w((k == 4), 2'b00, 4'b1111, {16'h2000 + 16'(k), 16'h1000 + 16'(k)}));
    compare_words("t4");

    // Response capture and stall handling; next burst recaptures.
`ifdef RPC2_RX_STALL_RESP_EN
    resp2 = 2'b11;
`else
    resp2 = 2'b01;
`endif
    send_half(16'h0A0A, 1'b0, 1'b0, 2'b01, 1'b0);
    send_half(16'h0B0B, 1'b1, 1'b0, 2'b00, 1'b0);
    send_half(16'h0C0C, 1'b0, 1'b0, 2'b00, 1'b1);
    send_half(16'h0D0D, 1'b1, 1'b1, 2'b00, 1'b0);
    send_half(16'h1234, 1'b0, 1'b1, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    exp_q.push_back(w(1'b0, 2'b01, 4'b1111, 32'h0B0B0A0A));
    exp_q.push_back(w(1'b1, resp2, 4'b1111, 32'h0D0D0C0C));
    exp_q.push_back(w(1'b1, 2'b00, 4'b0011, 32'h00001234));
    compare_words("t5");

    // Reset mid-burst with words queued and a half pending.
    bus.rd_ready = 1'b0;
    send_half(16'h3333, 1'b0, 1'b0, 2'b00, 1'b0);
    send_half(16'h4444, 1'b1, 1'b0, 2'b00, 1'b0);
    send_half(16'h3334, 1'b0, 1'b0, 2'b00, 1'b0);
    send_half(16'h4445, 1'b1, 1'b0, 2'b00, 1'b0);
    send_half(16'h7777, 1'b0, 1'b0, 2'b00, 1'b0);
    check("t6_queued_valid", 64'(bus.rd_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("t6_rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("t6_rst_rx_ready", 64'(bus.rx_data_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_post_rx_ready", 64'(bus.rx_data_ready), 64'd1);
    check("t6_post_rd_valid", 64'(bus.rd_valid), 64'd0);
    got_q.delete();
    bus.rd_ready = 1'b1;
    send_half(16'h5555, 1'b1, 1'b1, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    exp_q.push_back(w(1'b1, 2'b00, 4'b1100, 32'h55550000));
    compare_words("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
